spi_exe_master: RTL and testbench
=================================

Name: spi_exe_master

Overview:
- SPI master that drives one transaction frame into the SPI execution-unit slave.
- Accepts an operand/opcode request over a valid/ready handshake, generates SCLK from the system clock, serialises {argA, argB, oper} MSB first on MOSI, and captures the 12-bit response {result, flags} from MISO.
- Sits on the system-clock side, directly upstream of the slave. Owns CS, SCLK and MOSI.

Parameters:
- CLK_DIV, 2, system-clock cycles per SCLK half-period; must be ≥1.
- FRAME_BITS, 40, SCLK rising edges per frame; must be ≥ RESP_OFFSET+12.
- RESP_OFFSET, 26, index of the rising edge that launches result bit 7 on MISO. Tuned to the slave latency.

Ports:
- i_clk_p  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  master idle, can accept a request.
- i_argA  in  8  operand A.
- i_argB  in  8  operand B.
- i_oper  in  8  opcode byte; the slave uses bits [7:4].
- o_result  out  8  captured result.
- o_flags  out  4  captured flags {BF,NF,OF,SF}, bit 3..0.
- o_done  out  1  one-cycle pulse: o_result/o_flags updated.
- o_busy  out  1  frame in progress (not IDLE).
- o_sclk  out  1  SPI clock, idle low.
- o_cs  out  1  chip select, active low, idle high.
- o_mosi  out  1  serial data to the slave.
- i_miso  in  1  serial data from the slave; treated as synchronous to o_sclk.

Behaviour:
- Reset (async, any state): state=IDLE, o_cs=1, o_sclk=0, o_mosi=0, o_done=0, o_busy=0, o_ready=1, o_result=0, o_flags=0. Divider, bit counter and shift registers clear.
- All outputs are registered. No combinational path from i_valid to o_ready.
- Handshake: a request is accepted on a clock where i_valid && o_ready. The master latches {i_argA,i_argB,i_oper} into a 24-bit TX register padded with FRAME_BITS-24 zeros. o_ready=1 only in IDLE. i_valid outside IDLE is ignored, with no queuing.
- IDLE → SETUP on accept. Next cycle: o_cs=0, o_sclk=0, o_mosi=argA[7], o_busy=1, o_ready=0.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT: o_sclk toggles every CLK_DIV cycles, starting with a rising edge. Exactly FRAME_BITS high pulses are produced.
  - Rising edge k (k=0..FRAME_BITS-1) presents TX bit k on MOSI. The slave samples it there.
  - On each falling edge after rising edge k:
    - o_mosi advances to TX bit k+1, or 0 past the end.
    - If RESP_OFFSET ≤ k ≤ RESP_OFFSET+11, i_miso is shifted into a 12-bit RX register, MSB first: result[7]..result[0], then flags[3]..flags[0].
  - After the final falling edge (o_sclk=0), go to HOLD.
- HOLD: o_cs=0 and o_sclk=0 for CLK_DIV cycles. Then o_cs=1 and go to DONE.
- DONE: one cycle. o_result/o_flags load from RX, o_done=1, then go to IDLE. o_ready=1 on the following cycle.
- Latency: accept edge to o_done high = CLK_DIV*(2+2*FRAME_BITS)+1 cycles. This is 165 at defaults.
- Minimum gap between back-to-back frames: CS high for ≥1 IDLE cycle (CLK_DIV ≥1 system cycles). Every frame starts with a fresh CS assertion.
- o_result/o_flags hold their value between o_done pulses. They are never partially updated.
- Reset mid-frame: CS deasserts immediately (async), and no o_done is issued. The slave sees an aborted frame and is reset by the system.
- Counters: divider width $clog2(CLK_DIV+1), bit counter width $clog2(FRAME_BITS+1). No wrap inside a frame.
- Illegal/unused state encodings recover to IDLE with outputs at their idle values.

Test Plan:
- Reset: assert i_rst_n=0 mid-SHIFT → o_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_ready=1 within the same cycle, and no o_done.
- Single frame: argA=0x12, argB=0x34, oper=0x10, with a bench slave model returning result=0x46, flags=4'b0000 at offset 26. Required:
  - MOSI bits 0..23 sampled on SCLK rising edges = 0x123410, and bits 24..39 = 0.
  - Exactly 40 SCLK pulses.
  - o_done at cycle 165 with o_result=0x46, o_flags=0x0.
- Flags capture: model returns result=0x80, flags=4'b1010 → o_result=0x80, o_flags=0xA.
- Busy rejection: pulse i_valid with new data at cycle 50 of a frame → ignored; MOSI stream and result of the current frame unchanged, and no second frame starts.
- Back-to-back: i_valid held high with two requests → two frames, each with CS high between them, and two o_done pulses 166 cycles apart.
- CLK_DIV=1, FRAME_BITS=36, RESP_OFFSET=24 → SCLK period 2 cycles, o_done at cycle 75, and captured value matches the model.

Source files
------------

// File: rtl/spi_exe_master.sv
// SPI master for the execution-unit slave: serialises {argA, argB, oper} MSB first
// on MOSI and captures the 12-bit {result, flags} response from MISO.
module spi_exe_master #(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BITS  = 40,
    parameter int RESP_OFFSET = 26
) (
    input  logic       i_clk_p,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_argA,
    input  logic [7:0] i_argB,
    input  logic [7:0] i_oper,
    output logic [7:0] o_result,
    output logic [3:0] o_flags,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_cs,
    output logic       o_mosi,
    input  logic       i_miso
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    // Bit 0 of the frame lives in o_mosi, so the shifter only holds bits 1..FRAME_BITS-1.
    localparam int TX_W  = FRAME_BITS - 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt, div_d;
    logic [BIT_W-1:0] bit_cnt, bit_d;
    logic [TX_W-1:0]  tx_sh, tx_d;
    logic [11:0]      rx_sh, rx_d;
    logic             ready_d, done_d, busy_d, sclk_d, cs_d, mosi_d;
    logic [7:0]       result_d;
    logic [3:0]       flags_d;
    logic             div_end;
    logic             in_window;

    assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign in_window = (int'(bit_cnt) >= RESP_OFFSET) && (int'(bit_cnt) <= RESP_OFFSET + 11);

    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            o_ready  <= 1'b1;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
            o_sclk   <= 1'b0;
            o_cs     <= 1'b1;
            o_mosi   <= 1'b0;
            o_result <= '0;
            o_flags  <= '0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_d;
            bit_cnt  <= bit_d;
            tx_sh    <= tx_d;
            rx_sh    <= rx_d;
            o_ready  <= ready_d;
            o_done   <= done_d;
            o_busy   <= busy_d;
            o_sclk   <= sclk_d;
            o_cs     <= cs_d;
            o_mosi   <= mosi_d;
            o_result <= result_d;
            o_flags  <= flags_d;
        end
    end

    // Every output is computed one cycle ahead here so that all of them leave a flop.
    always_comb begin
        state_d  = state;
        div_d    = div_cnt;
        bit_d    = bit_cnt;
        tx_d     = tx_sh;
        rx_d     = rx_sh;
        ready_d  = o_ready;
        done_d   = 1'b0;
        busy_d   = o_busy;
        sclk_d   = o_sclk;
        cs_d     = o_cs;
        mosi_d   = o_mosi;
        result_d = o_result;
        flags_d  = o_flags;

        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_d = SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    tx_d[TX_W-1 -: 23] = {i_argA[6:0], i_argB, i_oper};
                    mosi_d  = i_argA[7];
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            SETUP: begin
                div_d = div_cnt + DIV_W'(1);
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_cnt + DIV_W'(1);
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~o_sclk;
                    // Falling edge: the slave launched its bit on the preceding rise.
                    if (o_sclk) begin
                        mosi_d = tx_sh[TX_W-1];
                        tx_d   = {tx_sh[TX_W-2:0], 1'b0};
                        if (in_window) begin
                            rx_d = {rx_sh[10:0], i_miso};
                        end
                        bit_d = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                div_d = div_cnt + DIV_W'(1);
                if (div_end) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = rx_sh[11:4];
                flags_d  = rx_sh[3:0];
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                mosi_d   = 1'b0;
                cs_d     = 1'b1;
                sclk_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_spi_exe_master.sv
// Scoreboard bench for spi_exe_master: two parameter sets, a behavioural SPI slave
// wrapped around a reference execution-unit model, and a decoupled o_done monitor.
module tb_spi_exe_master;
    localparam int CD0 = 2, FB0 = 40, RO0 = 26;
    localparam int CD1 = 1, FB1 = 36, RO1 = 24;

    typedef struct packed { logic [23:0] tx; logic [11:0] resp; } exp_t;
    typedef struct packed { logic [31:0] pulses; logic [63:0] bits; } frm_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        valid    [2];
    logic [7:0]  arg_a    [2];
    logic [7:0]  arg_b    [2];
    logic [7:0]  oper     [2];
    logic        miso     [2] = '{1'b0, 1'b0};
    logic        ready_w  [2];
    logic        done_w   [2];
    logic        busy_w   [2];
    logic        sclk_w   [2];
    logic        cs_w     [2];
    logic        mosi_w   [2];
    logic [7:0]  result_w [2];
    logic [3:0]  flags_w  [2];
    logic        ovr_en   [2];
    logic [11:0] ovr_resp [2];

    exp_t exp_q    [2][$];
    int   acc_q    [2][$];
    frm_t frm_q    [2][$];
    int   done_cyc [2][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_exe_master #(.CLK_DIV(CD0), .FRAME_BITS(FB0), .RESP_OFFSET(RO0)) dut0 (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready_w[0]),
        .i_argA(arg_a[0]), .i_argB(arg_b[0]), .i_oper(oper[0]),
        .o_result(result_w[0]), .o_flags(flags_w[0]), .o_done(done_w[0]), .o_busy(busy_w[0]),
        .o_sclk(sclk_w[0]), .o_cs(cs_w[0]), .o_mosi(mosi_w[0]), .i_miso(miso[0])
    );

    spi_exe_master #(.CLK_DIV(CD1), .FRAME_BITS(FB1), .RESP_OFFSET(RO1)) dut1 (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready_w[1]),
        .i_argA(arg_a[1]), .i_argB(arg_b[1]), .i_oper(oper[1]),
        .o_result(result_w[1]), .o_flags(flags_w[1]), .o_done(done_w[1]), .o_busy(busy_w[1]),
        .o_sclk(sclk_w[1]), .o_cs(cs_w[1]), .o_mosi(mosi_w[1]), .i_miso(miso[1])
    );

    function automatic int fb_of(input int g);
        return (g == 0) ? FB0 : FB1;
    endfunction

    function automatic int ro_of(input int g);
        return (g == 0) ? RO0 : RO1;
    endfunction

    function automatic int lat_of(input int g);
        int cd;
        cd = (g == 0) ? CD0 : CD1;
        return cd * (2 + 2 * fb_of(g)) + 1;
    endfunction

    // Stand-in execution unit: {result, BF, NF, OF, SF} where SF marks a zero result.
    function automatic logic [11:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       bf;
        logic       ovf;
        w   = '0;
        bf  = 1'b0;
        ovf = 1'b0;
        case (op[7:4])
            4'h1: begin
                w   = {1'b0, a} + {1'b0, b};
                r   = w[7:0];
                bf  = w[8];
                ovf = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h2: begin
                w   = {1'b0, a} - {1'b0, b};
                r   = w[7:0];
                bf  = w[8];
                ovf = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            default: r = a;
        endcase
        return {r, bf, r[7], ovf, (r == 8'h00)};
    endfunction

    task automatic checkOutput(input string name, input int g, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s cfg%0d: got 0x%0h, expected 0x%0h", name, g, act, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int g);
        checkOutput({tag, "_cs"},     g, 64'(cs_w[g]),     64'd1);
        checkOutput({tag, "_sclk"},   g, 64'(sclk_w[g]),   64'd0);
        checkOutput({tag, "_mosi"},   g, 64'(mosi_w[g]),   64'd0);
        checkOutput({tag, "_busy"},   g, 64'(busy_w[g]),   64'd0);
        checkOutput({tag, "_ready"},  g, 64'(ready_w[g]),  64'd1);
        checkOutput({tag, "_done"},   g, 64'(done_w[g]),   64'd0);
        checkOutput({tag, "_result"}, g, 64'(result_w[g]), 64'd0);
        checkOutput({tag, "_flags"},  g, 64'(flags_w[g]),  64'd0);
    endtask

    // Called just after a rising clock edge; returns just after the accepting edge.
    task automatic applyStimulus(input int g, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] op, input bit hold);
        exp_t e;
        int   n;
        e.tx   = {a, b, op};
        e.resp = ovr_en[g] ? ovr_resp[g] : alu(a, b, op);
        exp_q[g].push_back(e);
        arg_a[g] = a;
        arg_b[g] = b;
        oper[g]  = op;
        valid[g] = 1'b1;
        n = 0;
        while (!ready_w[g] && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_w[g]) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout cfg%0d: ready=%0b, expected 1", g, ready_w[g]);
            void'(exp_q[g].pop_back());
            valid[g] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!hold) valid[g] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (exp_q[g].size() != 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q[g].size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout cfg%0d: %0d frames outstanding, expected 0", g, exp_q[g].size());
        end
    endtask

    task automatic back_to_back(input int g);
        int n0;
        n0 = done_cyc[g].size();
        applyStimulus(g, 8'($urandom), 8'($urandom), 8'h10, 1'b1);
        applyStimulus(g, 8'($urandom), 8'($urandom), 8'h20, 1'b0);
        wait_idle(g);
        if (done_cyc[g].size() >= n0 + 2) begin
            checkOutput("done_gap", g, 64'(done_cyc[g][n0+1] - done_cyc[g][n0]), 64'(lat_of(g) + 1));
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL done_count cfg%0d: got %0d pulses, expected 2", g, done_cyc[g].size() - n0);
        end
    endtask

    int          pulses    [2];
    logic [63:0] frame     [2];
    logic [23:0] rx24      [2];
    logic [11:0] sresp     [2];
    logic        cs_prev   [2] = '{1'b1, 1'b1};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    int          k_s;
    int          acc_s;
    exp_t        e_s;
    frm_t        f_s;

    // Slave model and o_done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n) begin
                if (valid[g] && ready_w[g]) acc_q[g].push_back(cyc);
                if (!cs_w[g] && cs_prev[g]) begin
                    pulses[g] = 0;
                    frame[g]  = '0;
                    rx24[g]   = '0;
                end
                if (!cs_w[g] && sclk_w[g] && !sclk_prev[g]) begin
                    k_s = pulses[g];
                    frame[g] = {frame[g][62:0], mosi_w[g]};
                    if (k_s < 24) rx24[g] = {rx24[g][22:0], mosi_w[g]};
                    if (k_s == ro_of(g))
                        sresp[g] = ovr_en[g] ? ovr_resp[g] : alu(rx24[g][23:16], rx24[g][15:8], rx24[g][7:0]);
                    if (k_s >= ro_of(g) && k_s <= ro_of(g) + 11)
                        miso[g] = sresp[g][11 - (k_s - ro_of(g))];
                    else
                        miso[g] = 1'($urandom);
                    pulses[g] = pulses[g] + 1;
                end
                if (cs_w[g] && !cs_prev[g]) begin
                    f_s.pulses = 32'(pulses[g]);
                    f_s.bits   = frame[g];
                    frm_q[g].push_back(f_s);
                end
                if (done_w[g]) begin
                    done_cyc[g].push_back(cyc);
                    if (exp_q[g].size() == 0 || acc_q[g].size() == 0 || frm_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done cfg%0d: got done with %0d pending requests, expected none",
                                 g, exp_q[g].size());
                    end else begin
                        e_s   = exp_q[g].pop_front();
                        acc_s = acc_q[g].pop_front();
                        f_s   = frm_q[g].pop_front();
                        checkOutput("result",      g, 64'(result_w[g]), 64'(e_s.resp[11:4]));
                        checkOutput("flags",       g, 64'(flags_w[g]),  64'(e_s.resp[3:0]));
                        checkOutput("latency",     g, 64'(cyc - acc_s - 1), 64'(lat_of(g)));
                        checkOutput("mosi_frame",  g, f_s.bits, 64'(e_s.tx) << (fb_of(g) - 24));
                        checkOutput("sclk_pulses", g, 64'(f_s.pulses), 64'(fb_of(g)));
                        checkOutput("ready_at_done", g, 64'(ready_w[g]), 64'd1);
                    end
                end
            end
            cs_prev[g]   = cs_w[g];
            sclk_prev[g] = sclk_w[g];
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0;
        int n_done [2];
        for (int g = 0; g < 2; g++) begin
            valid[g]    = 1'b0;
            arg_a[g]    = '0;
            arg_b[g]    = '0;
            oper[g]     = '0;
            ovr_en[g]   = 1'b0;
            ovr_resp[g] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check_idle_outputs("reset", g);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames, response flags override, busy rejection and back-to-back.
        for (int g = 0; g < 2; g++) begin
            applyStimulus(g, 8'h12, 8'h34, 8'h10, 1'b0);
            wait_idle(g);
            ovr_en[g]   = 1'b1;
            ovr_resp[g] = 12'h80A;
            applyStimulus(g, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            wait_idle(g);
            ovr_en[g] = 1'b0;
        end

        n0 = done_cyc[0].size();
        applyStimulus(0, 8'hA5, 8'h3C, 8'h20, 1'b0);
        repeat (49) @(posedge clk);
        #1;
        arg_a[0] = 8'hFF;
        arg_b[0] = 8'h01;
        oper[0]  = 8'h50;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (200) @(posedge clk);
        #1;
        checkOutput("busy_reject_frames", 0, 64'(done_cyc[0].size()), 64'(n0 + 1));

        back_to_back(0);
        back_to_back(1);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(g, 8'($urandom), 8'($urandom),
                              {4'($urandom_range(0, 6)), 4'($urandom)},
                              (i < 7) && ($urandom_range(0, 1) == 1));
            end
            wait_idle(g);
        end

        // Abort both masters mid-SHIFT and confirm no completion follows.
        applyStimulus(0, 8'($urandom), 8'($urandom), 8'h30, 1'b0);
        applyStimulus(1, 8'($urandom), 8'($urandom), 8'h40, 1'b0);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) check_idle_outputs("abort", g);
        repeat (2) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            exp_q[g].delete();
            acc_q[g].delete();
            frm_q[g].delete();
            n_done[g] = done_cyc[g].size();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++)
            checkOutput("no_done_after_abort", g, 64'(done_cyc[g].size()), 64'(n_done[g]));

        for (int g = 0; g < 2; g++) begin
            applyStimulus(g, 8'($urandom), 8'($urandom), 8'h10, 1'b0);
            wait_idle(g);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
